// File: rtl/enc_capture.sv
// Quadrature encoder front end: synchronises A/B/Z, decodes x4 into a signed position,
// timestamps each legal step and streams {timestamp, position} through a FWFT sample FIFO.
module enc_capture #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter bit          CLR_ON_INDEX = 1'b0
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_z,
  input  logic        enable,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] position,
  output logic [15:0] overflow_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q, z_sync_q;
  logic [1:0]             ab_prev_q;
  logic                   z_prev_q;
  logic [31:0]            pos_q, pos_d;
  logic [31:0]            ts_q;
  logic                   pend_q, pend_d;
  logic [15:0]            ovf_q, err_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic [64:0]            mem_q [FIFO_DEPTH];

  logic [1:0] ab_cur, delta_idx;
  logic       step_fwd, step_rev, illegal, z_rise;
  logic       push, pop, full, wr_en, drop, tuser_in;

  // Map Gray-coded AB onto a 2-bit ring index so a step is a +/-1 difference.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    ab_cur    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    delta_idx = gray_idx(ab_cur) - gray_idx(ab_prev_q);
    step_fwd  = (delta_idx == 2'd1);
    step_rev  = (delta_idx == 2'd3);
    illegal   = (delta_idx == 2'd2);
    z_rise    = z_sync_q[SYNC_STAGES-1] & ~z_prev_q;

    pos_d = (CLR_ON_INDEX && z_rise) ? 32'd0 : pos_q;
    if (step_fwd) begin
      pos_d = pos_d + 32'd1;
    end else if (step_rev) begin
      pos_d = pos_d - 32'd1;
    end

    push     = (step_fwd | step_rev) & enable;
    tuser_in = pend_q | z_rise;
    pend_d   = push ? 1'b0 : (pend_q | z_rise);

    m_axis_tvalid = (count_q != '0);
    pop           = m_axis_tvalid & m_axis_tready;
    full          = (count_q == CntW'(FIFO_DEPTH));
    wr_en         = push & (~full | pop);
    drop          = push & full & ~pop;
    count_d       = count_q + CntW'(wr_en) - CntW'(pop);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      a_sync_q  <= '0;
      b_sync_q  <= '0;
      z_sync_q  <= '0;
      ab_prev_q <= 2'b00;
      z_prev_q  <= 1'b0;
      pos_q     <= '0;
      ts_q      <= '0;
      pend_q    <= 1'b0;
      ovf_q     <= '0;
      err_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      a_sync_q  <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
      b_sync_q  <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
      z_sync_q  <= {z_sync_q[SYNC_STAGES-2:0], enc_z};
      ab_prev_q <= ab_cur;
      z_prev_q  <= z_sync_q[SYNC_STAGES-1];
      pos_q     <= pos_d;
      ts_q      <= ts_q + 32'd1;
      pend_q    <= pend_d;
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      if (illegal && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {tuser_in, ts_q, pos_d};
  end

  always_comb begin
    m_axis_tdata = m_axis_tvalid ? mem_q[rd_ptr_q][63:0] : 64'd0;
    m_axis_tuser = m_axis_tvalid & mem_q[rd_ptr_q][64];
    m_axis_tlast = m_axis_tvalid;
    position     = pos_q;
    overflow_cnt = ovf_q;
    err_cnt      = err_q;
  end

endmodule

// File: tb/tb_enc_capture.sv
// Scoreboard bench for enc_capture: a position/tuser model queues expected beats as steps
// are driven; a negedge monitor pops and compares each accepted beat.
module tb_enc_capture;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        areset, enc_a, enc_b, enc_z, enable, m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tvalid, m_axis_tlast;
  logic [31:0] position;
  logic [15:0] overflow_cnt, err_cnt;

  logic [63:0] d2_tdata;
  logic        d2_tuser, d2_tvalid, d2_tlast;
  logic [31:0] d2_position;
  logic [15:0] d2_ovf, d2_err;

  always #5 clk = ~clk;

  enc_capture #(.SYNC_STAGES(2), .FIFO_DEPTH(Depth), .CLR_ON_INDEX(1'b0)) dut (
    .clk(clk), .areset(areset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .enable(enable), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .position(position), .overflow_cnt(overflow_cnt),
    .err_cnt(err_cnt)
  );

  // Index-clearing variant shares the encoder inputs; only its position is checked.
  enc_capture #(.SYNC_STAGES(2), .FIFO_DEPTH(Depth), .CLR_ON_INDEX(1'b1)) dut_clr (
    .clk(clk), .areset(areset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .enable(enable), .m_axis_tdata(d2_tdata), .m_axis_tuser(d2_tuser),
    .m_axis_tvalid(d2_tvalid), .m_axis_tready(1'b1), .m_axis_tlast(d2_tlast),
    .position(d2_position), .overflow_cnt(d2_ovf), .err_cnt(d2_err)
  );

  typedef struct packed {
    logic        tuser;
    logic [31:0] pos;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          idx;
  logic [31:0] pos_m;
  logic        pend_m;
  int          ovf_m, err_m;
  logic        chk_spacing = 1'b0;
  logic        have_prev = 1'b0;
  logic [31:0] last_ts;
  logic [1:0]  gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      check("tlast", 64'(m_axis_tlast), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        check("beat_pos", 64'(m_axis_tdata[31:0]), 64'(e.pos));
        check("beat_tuser", 64'(m_axis_tuser), 64'(e.tuser));
      end
      if (chk_spacing && have_prev)
        check("ts_spacing", 64'(m_axis_tdata[63:32] - last_ts), 64'd8);
      last_ts   = m_axis_tdata[63:32];
      have_prev = 1'b1;
    end
  end

  task automatic model_push();
    if (enable) begin
      if (exp_q.size() < Depth) exp_q.push_back('{tuser: pend_m, pos: pos_m});
      else ovf_m++;
      pend_m = 1'b0;
    end
  endtask

  task automatic step(input int dir, input logic with_z);
    @(posedge clk); #1;
    idx = (idx + dir) & 3;
    {enc_a, enc_b} = gray_tab[idx];
    if (with_z) begin
      enc_z  = 1'b1;
      pend_m = 1'b1;
    end
    pos_m = pos_m + 32'(dir);
    model_push();
    repeat (7) @(posedge clk);
  endtask

  task automatic illegal_jump();
    @(posedge clk); #1;
    idx = (idx + 2) & 3;
    {enc_a, enc_b} = gray_tab[idx];
    err_m++;
    repeat (7) @(posedge clk);
  endtask

  task automatic z_pulse();
    @(posedge clk); #1;
    enc_z  = 1'b1;
    pend_m = 1'b1;
    repeat (4) @(posedge clk);
    #1 enc_z = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic model_clear();
    enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
    idx = 0; pos_m = '0; pend_m = 1'b0; ovf_m = 0; err_m = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    areset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    areset = 1'b1; enable = 1'b1; m_axis_tready = 1'b1;
    model_clear();
    #12;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_position", 64'(position), 64'd0);
    check("rst_ovf", 64'(overflow_cnt), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    do_reset();

    // Four forward steps, 8 cycles apart.
    have_prev = 1'b0; chk_spacing = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 1'b0);
    wait_drain();
    chk_spacing = 1'b0;
    check("fwd_position", 64'(position), 64'(pos_m));

    // Reverse from zero, then a two-bit jump.
    do_reset();
    for (int i = 0; i < 4; i++) step(-1, 1'b0);
    illegal_jump();
    wait_drain();
    check("rev_position", 64'(position), 64'hFFFF_FFFC);
    check("err_cnt", 64'(err_cnt), 64'(err_m));

    // Index flag carried into the next beat only.
    z_pulse();
    step(1, 1'b0);
    step(1, 1'b0);
    wait_drain();

    // Z rise coincident with a step: clearing variant restarts from zero.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1'b0);
    wait_drain();
    check("clr_pre_pos", 64'(d2_position), 64'd5);
    step(1, 1'b1);
    wait_drain();
    check("noclr_pos", 64'(position), 64'd6);
    check("clr_pos", 64'(d2_position), 64'd1);
    #1 enc_z = 1'b0;
    repeat (4) @(posedge clk);

    // Overflow: 20 steps into a stalled 16-deep FIFO.
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) step(1, 1'b0);
    check("ovf_cnt", 64'(overflow_cnt), 64'(ovf_m));
    check("ovf_tvalid", 64'(m_axis_tvalid), 64'd1);
    // Push lands on the same edge as a single pop while full.
    @(posedge clk); #1;
    idx = (idx + 1) & 3;
    {enc_a, enc_b} = gray_tab[idx];
    pos_m = pos_m + 32'd1;
    @(posedge clk); @(posedge clk); #1;
    m_axis_tready = 1'b1;
    exp_q.push_back('{tuser: 1'b0, pos: pos_m});
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    repeat (4) @(posedge clk);
    check("ovf_no_extra", 64'(overflow_cnt), 64'(ovf_m));
    #1 m_axis_tready = 1'b1;
    wait_drain();

    // Track-only mode, then a single push.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 1'b0);
    repeat (4) @(posedge clk);
    check("dis_position", 64'(position), 64'd3);
    check("dis_tvalid", 64'(m_axis_tvalid), 64'd0);
    #1 enable = 1'b1;
    step(1, 1'b0);
    wait_drain();
    check("en_position", 64'(position), 64'd4);

    // Asynchronous reset in the middle of a queued burst.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 1'b0);
    illegal_jump();
    check("burst_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("burst_err", 64'(err_cnt), 64'd1);
    @(posedge clk); #3;
    areset = 1'b1;
    model_clear();
    #1;
    check("async_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("async_position", 64'(position), 64'd0);
    check("async_err", 64'(err_cnt), 64'd0);
    check("async_ovf", 64'(overflow_cnt), 64'd0);
    check("async_tdata", m_axis_tdata, 64'd0);
    @(posedge clk); #1 areset = 1'b0;
    m_axis_tready = 1'b1;
    repeat (6) @(posedge clk);
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
